// File: rtl/parity_ram.sv
// parity_ram: parametrised word store with one parity bit per word, an INIT
// clearing sweep after reset, parity-fault injection on write, and an error
// log (sticky flag, saturating count, first failing address) fed by reads.
module parity_ram #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ODD_PAR = 0,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inj_err,
  input  logic              clr_err,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              par_err,
  output logic              err_seen,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef enum logic {INIT, RUN} state_t;

  // Storage: parity bit lives in the MSB of each word.
  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_d;
  logic [DATA_W-1:0] rdata_d;
  logic              rvalid_d;
  logic              par_err_d;
  logic              err_seen_d;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [ADDR_W-1:0] err_addr_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wword;
  logic [WORD_W-1:0] rd_word;
  logic              rd_perr;
  logic              par_cfg;

  assign par_cfg = 1'(ODD_PAR);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      busy     <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
      par_err  <= 1'b0;
      err_seen <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy     <= busy_d;
      rdata    <= rdata_d;
      rvalid   <= rvalid_d;
      par_err  <= par_err_d;
      err_seen <= err_seen_d;
      err_cnt  <= err_cnt_d;
      err_addr <= err_addr_d;
    end
  end

  // Memory write port; old contents are read combinationally, so a same-cycle
  // read of the written address returns the previous word.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Next-state: INIT sweep, RUN-mode access, parity check and error log.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = busy;
    rdata_d    = rdata;
    rvalid_d   = 1'b0;
    par_err_d  = 1'b0;
    err_seen_d = err_seen;
    err_cnt_d  = err_cnt;
    err_addr_d = err_addr;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wword  = {par_cfg, DATA_W'(0)};
    rd_word    = mem[addr];
    rd_perr    = (^rd_word) ^ par_cfg;

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wword = {par_cfg, DATA_W'(0)};
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end
      end
      RUN: begin
        if (wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = addr;
          mem_wword = {(^wdata) ^ par_cfg ^ inj_err, wdata};
        end
        // Clear first so a simultaneous erroring read is logged on top of it.
        if (clr_err) begin
          err_seen_d = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
        end
        if (rd_en) begin
          rdata_d   = rd_word[DATA_W-1:0];
          rvalid_d  = 1'b1;
          par_err_d = rd_perr;
          if (rd_perr) begin
            if (err_cnt_d != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_d + CNT_W'(1);
            end
            if (!err_seen_d) begin
              err_seen_d = 1'b1;
              err_addr_d = addr;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_parity_ram.sv
// Testbench for parity_ram: even-parity instance checked through a read
// scoreboard plus inline log checks; an odd-parity instance checked inline.
module tb_parity_ram;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0, rd_en = 1'b0, inj_err = 1'b0, clr_err = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              busy, rvalid, par_err, err_seen;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] err_addr;

  logic              o_wr_en = 1'b0, o_rd_en = 1'b0, o_inj_err = 1'b0, o_clr_err = 1'b0;
  logic [ADDR_W-1:0] o_addr = '0;
  logic [DATA_W-1:0] o_wdata = '0;
  logic              o_busy, o_rvalid, o_par_err, o_err_seen;
  logic [DATA_W-1:0] o_rdata;
  logic [CNT_W-1:0]  o_err_cnt;
  logic [ADDR_W-1:0] o_err_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              pe;
  } beat_t;
  beat_t sb[$];

  bit tb_run = 1'b0;
  bit exp_rv = 1'b0;

  always #5 clk = ~clk;

  parity_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ODD_PAR(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .inj_err(inj_err), .clr_err(clr_err), .busy(busy), .rdata(rdata), .rvalid(rvalid),
    .par_err(par_err), .err_seen(err_seen), .err_cnt(err_cnt), .err_addr(err_addr)
  );

  parity_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ODD_PAR(1), .CNT_W(CNT_W)) dut_odd (
    .clk(clk), .rst(rst), .wr_en(o_wr_en), .rd_en(o_rd_en), .addr(o_addr), .wdata(o_wdata),
    .inj_err(o_inj_err), .clr_err(o_clr_err), .busy(o_busy), .rdata(o_rdata),
    .rvalid(o_rvalid), .par_err(o_par_err), .err_seen(o_err_seen), .err_cnt(o_err_cnt),
    .err_addr(o_err_addr)
  );

  // Expected rvalid: a read accepted at an edge in RUN yields a beat after it.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_rv <= 1'b0;
    else     exp_rv <= rd_en && tb_run;
  end

  // Scoreboard monitor for the even-parity instance.
  always @(negedge clk) begin
    beat_t b;
    #1;
    checks++;
    if (rvalid !== exp_rv) begin
      errors++;
      $display("FAIL rvalid_timing: got %b expected %b at %0t", rvalid, exp_rv, $time);
    end
    if (rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: rdata %h with empty scoreboard at %0t", rdata, $time);
      end else begin
        b = sb.pop_front();
        if (rdata !== b.d || par_err !== b.pe) begin
          errors++;
          $display("FAIL read_beat: got rdata %h par_err %b expected %h %b at %0t",
                   rdata, par_err, b.d, b.pe, $time);
        end
      end
    end
  end

  // All drivers start and end at negedge+1.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
    wr_en = 1'b1; addr = a; wdata = d; inj_err = inj;
    @(negedge clk); #1;
    wr_en = 1'b0; inj_err = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ed, input logic ep,
                    input logic clr);
    rd_en = 1'b1; addr = a; clr_err = clr;
    sb.push_back('{d: ed, pe: ep});
    @(negedge clk); #1;
    rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s: busy high for %0d cycles expected 8", name, n);
    end
  endtask

  task automatic test_reset;
    idle(3);
    checks++;
    if (busy !== 1'b1 || rdata !== 8'h00 || rvalid !== 1'b0 || par_err !== 1'b0 ||
        err_seen !== 1'b0 || err_cnt !== 4'd0 || err_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: busy %b rdata %h rvalid %b par_err %b seen %b cnt %0d addr %0d expected 1 00 0 0 0 0 0",
               busy, rdata, rvalid, par_err, err_seen, err_cnt, err_addr);
    end
    rst = 1'b0;
    count_busy("init_busy_len");
    tb_run = 1'b1;
    for (int i = 0; i < 8; i++) rd(ADDR_W'(i), 8'h00, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_write_read;
    logic [DATA_W:0] w;
    wr(3'd0, 8'h1F, 1'b0);
    wr(3'd1, 8'h31, 1'b0);
    rd(3'd0, 8'h1F, 1'b0, 1'b0);
    rd(3'd1, 8'h31, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      w = dut.mem[i];
      checks++;
      if (w[DATA_W] !== 1'b1) begin
        errors++;
        $display("FAIL stored_parity_%0d: got %b expected 1", i, w[DATA_W]);
      end
    end
  endtask

  task automatic test_inject;
    wr(3'd5, 8'hA5, 1'b1);
    rd(3'd5, 8'hA5, 1'b1, 1'b0);
    rd(3'd5, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 4'd2 || err_addr !== 3'd5 || err_seen !== 1'b1) begin
      errors++;
      $display("FAIL inject_log: cnt %0d addr %0d seen %b expected 2 5 1", err_cnt, err_addr, err_seen);
    end
    wr(3'd3, 8'h12, 1'b1);
    rd(3'd3, 8'h12, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 4'd3 || err_addr !== 3'd5) begin
      errors++;
      $display("FAIL inject_second: cnt %0d addr %0d expected 3 5", err_cnt, err_addr);
    end
  endtask

  task automatic test_saturate_clear;
    for (int i = 0; i < 20; i++) rd(3'd5, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 4'd15) begin
      errors++;
      $display("FAIL saturate: cnt %0d expected 15", err_cnt);
    end
    clr_err = 1'b1;
    @(negedge clk); #1;
    clr_err = 1'b0;
    checks++;
    if (err_cnt !== 4'd0 || err_seen !== 1'b0 || err_addr !== 3'd0) begin
      errors++;
      $display("FAIL clear: cnt %0d seen %b addr %0d expected 0 0 0", err_cnt, err_seen, err_addr);
    end
    wr(3'd2, 8'h0C, 1'b1);
    wr(3'd6, 8'h0C, 1'b1);
    rd(3'd6, 8'h0C, 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 4'd1 || err_addr !== 3'd6) begin
      errors++;
      $display("FAIL pre_clr_race: cnt %0d addr %0d expected 1 6", err_cnt, err_addr);
    end
    rd(3'd2, 8'h0C, 1'b1, 1'b1);
    checks++;
    if (err_cnt !== 4'd1 || err_addr !== 3'd2 || err_seen !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_error: cnt %0d addr %0d seen %b expected 1 2 1", err_cnt, err_addr, err_seen);
    end
  endtask

  task automatic test_back_to_back;
    wr(3'd4, 8'h55, 1'b0);
    wr_en = 1'b1; wdata = 8'h66;
    rd(3'd4, 8'h55, 1'b0, 1'b0);
    wr_en = 1'b0;
    rd(3'd4, 8'h66, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d beats outstanding expected 0", sb.size());
    end
  endtask

  task automatic test_mid_reset;
    rd_en = 1'b1; addr = 3'd2;
    #2;
    rst = 1'b1; tb_run = 1'b0;
    #1;
    rd_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || rdata !== 8'h00 || rvalid !== 1'b0 || par_err !== 1'b0 ||
        err_seen !== 1'b0 || err_cnt !== 4'd0 || err_addr !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: busy %b rdata %h rvalid %b cnt %0d seen %b addr %0d expected 1 00 0 0 0 0",
               busy, rdata, rvalid, err_cnt, err_seen, err_addr);
    end
    idle(2);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_read: rvalid %b expected 0", rvalid);
    end
    rst = 1'b0;
    count_busy("reinit_busy_len");
    tb_run = 1'b1;
    rd(3'd4, 8'h00, 1'b0, 1'b0);
    rd(3'd2, 8'h00, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_odd_parity;
    logic [DATA_W:0] w;
    for (int i = 0; i < 8; i++) begin
      o_rd_en = 1'b1; o_addr = ADDR_W'(i);
      @(negedge clk); #1;
      o_rd_en = 1'b0;
      checks++;
      if (o_rvalid !== 1'b1 || o_par_err !== 1'b0 || o_rdata !== 8'h00) begin
        errors++;
        $display("FAIL odd_init_read_%0d: rvalid %b par_err %b rdata %h expected 1 0 00",
                 i, o_rvalid, o_par_err, o_rdata);
      end
    end
    o_wr_en = 1'b1; o_addr = 3'd6; o_wdata = 8'h00;
    @(negedge clk); #1;
    o_wr_en = 1'b0;
    w = dut_odd.mem[6];
    checks++;
    if (w[DATA_W] !== 1'b1) begin
      errors++;
      $display("FAIL odd_stored_parity: got %b expected 1", w[DATA_W]);
    end
    o_wr_en = 1'b1; o_addr = 3'd7; o_wdata = 8'h03; o_inj_err = 1'b1;
    @(negedge clk); #1;
    o_wr_en = 1'b0; o_inj_err = 1'b0;
    o_rd_en = 1'b1; o_addr = 3'd7;
    @(negedge clk); #1;
    o_rd_en = 1'b0;
    checks++;
    if (o_rdata !== 8'h03 || o_par_err !== 1'b1 || o_err_cnt !== 4'd1 || o_err_addr !== 3'd7) begin
      errors++;
      $display("FAIL odd_inject: rdata %h par_err %b cnt %0d addr %0d expected 03 1 1 7",
               o_rdata, o_par_err, o_err_cnt, o_err_addr);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_inject;
    test_saturate_clear;
    test_back_to_back;
    test_mid_reset;
    test_odd_parity;
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d beats outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
